ncpu32k_regfile_mp: RTL and testbench
=====================================

Name: ncpu32k_regfile_mp

Overview:
Parametrised multi-port architectural register file, successor to the fixed 2-write/4-read regfile. Read-port count, write-port count, width and depth are generic. Adds in-block write-to-read bypass (selectable), a hardwired-zero register option and deterministic write-conflict priority. Sits between the issue stage (reads) and writeback/commit (writes) of the superscalar core.

Parameters:
AW, 5, register address width; depth = 2**AW
DW, 32, data width
NR, 4, number of read ports (>=1)
NW, 2, number of write ports (>=1)
ENABLE_BYPASS, 1, 1 = same-cycle write data forwarded to matching read; 0 = read returns pre-write value
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
raddr  in  NR*AW  read addresses; port k at [k*AW +: AW]
re  in  NR  read enables, bit k for port k
dout  out  NR*DW  registered read data; port k at [k*DW +: DW]
waddr  in  NW*AW  write addresses; port j at [j*AW +: AW]
wdat  in  NW*DW  write data; port j at [j*DW +: DW]
we  in  NW  write enables, bit j for port j

Behaviour:
- Reset: rst_n low asynchronously clears every storage entry and every dout lane to 0; holds while low. Reset asserted mid-operation discards any write or read in flight that cycle.
- Read latency 1: at posedge with re[k]=1, dout lane k loads value of raddr[k]; with re[k]=0 lane k holds previous value (not cleared).
- Write: at posedge each port j with we[j]=1 updates entry waddr[j] with wdat[j]; visible to reads issued next cycle onward.
- Write conflict: two or more enabled ports same address same cycle -> highest-index port j wins; others discarded; no error.
- Bypass (ENABLE_BYPASS=1): re[k]=1 and some enabled write port targets raddr[k] in same cycle -> dout lane k loads that write data (highest-index matching port, same priority as storage). Result equals storage content after the edge.
- No bypass (ENABLE_BYPASS=0): dout lane k loads storage content before the edge (old value).
- ZERO_REG=1: writes to address 0 dropped (storage and bypass); read of address 0 returns 0 regardless of bypass. ZERO_REG=0: entry 0 behaves as any other.
- All NR read ports independent; any number may read the same address.
- Simulation only, under NCPU_ENABLE_ASSERT with ZERO_REG=1: $fatal on any cycle with we[j]=1 and waddr[j]=0 ("writing to nil register").
- Out-of-range addresses impossible (depth = 2**AW).
- Expected implementation: flop-array storage, per-port priority mux, generate loops over NR/NW.

Test Plan:
- Reset: drive writes, assert rst_n low mid-cycle -> all dout = 0 immediately; after release read addr 5 on all ports -> 0.
- Basic write/read (defaults): cycle0 we[0]=1 waddr0=3 wdat0=0xDEADBEEF; cycle1 re[2]=1 raddr2=3 -> dout lane2 = 0xDEADBEEF after edge; cycle2 re[2]=0 -> lane2 holds 0xDEADBEEF.
- Bypass: reg 7 = 0x11; same cycle we[1]=1 waddr1=7 wdat1=0x22 and re[0]=1 raddr0=7 -> lane0 = 0x22 (ENABLE_BYPASS=1) / 0x11 (ENABLE_BYPASS=0); next-cycle read -> 0x22 in both.
- Conflict: we=2'b11, both waddr=9, wdat0=0xAAAA, wdat1=0x5555, re[3]=1 raddr3=9 -> lane3 = 0x5555 (bypass), later read of 9 -> 0x5555.
- Zero register: we[0]=1 waddr0=0 wdat0=0xFFFFFFFF with assert disabled, re[1]=1 raddr1=0 -> lane1 = 0 same and next cycle; with ZERO_REG=0 next-cycle read -> 0xFFFFFFFF.
- Parametrisation: NR=6, NW=3, AW=6, DW=64 -> write 0x0123456789ABCDEF to reg 63 via port 2, read on all 6 ports -> all lanes match.

Source files
------------

// File: rtl/ncpu32k_regfile_mp_if.sv
// Port bundle for the multi-port register file.
// The bundle carries the read request/response lanes and the write lanes.
interface ncpu32k_regfile_mp_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32,
    parameter int unsigned NR = 4,
    parameter int unsigned NW = 2
);
    logic [NR*AW-1:0] raddr;
    logic [NR-1:0]    re;
    logic [NR*DW-1:0] dout;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdat;
    logic [NW-1:0]    we;

    modport master (output raddr, re, waddr, wdat, we, input dout);
    modport slave  (input raddr, re, waddr, wdat, we, output dout);
endinterface

// File: rtl/ncpu32k_regfile_mp.sv
// Parametrised multi-port architectural register file.
// Reads are registered, writes use last-port-wins priority, and same-cycle bypass is optional.
module ncpu32k_regfile_mp #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32,
    parameter int unsigned NR = 4,
    parameter int unsigned NW = 2,
    parameter int          ENABLE_BYPASS = 1,
    parameter int          ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ncpu32k_regfile_mp_if.slave rf
);
    localparam int unsigned DEPTH = 2**AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [NR*DW-1:0] dout_q;
    logic [NR*DW-1:0] dout_d;

    // Later ports overwrite earlier ones, so the highest-index enabled port wins.
    always_comb begin : write_merge
        mem_d = mem_q;
        for (int unsigned j = 0; j < NW; j++) begin
            if (rf.we[j] && !(ZERO_REG != 0 && rf.waddr[j*AW +: AW] == '0)) begin
                mem_d[rf.waddr[j*AW +: AW]] = rf.wdat[j*DW +: DW];
            end
        end
    end

    // Bypass reads the merged next-state, so it matches post-edge storage exactly.
    always_comb begin : read_select
        dout_d = dout_q;
        for (int unsigned k = 0; k < NR; k++) begin
            if (rf.re[k]) begin
                if (ZERO_REG != 0 && rf.raddr[k*AW +: AW] == '0) begin
                    dout_d[k*DW +: DW] = '0;
                end else if (ENABLE_BYPASS != 0) begin
                    dout_d[k*DW +: DW] = mem_d[rf.raddr[k*AW +: AW]];
                end else begin
                    dout_d[k*DW +: DW] = mem_q[rf.raddr[k*AW +: AW]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign rf.dout = dout_q;

`ifdef NCPU_ENABLE_ASSERT
    always_ff @(posedge clk) begin
        if (rst_n && ZERO_REG != 0) begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (rf.we[j] && rf.waddr[j*AW +: AW] == '0) begin
                    $fatal(1, "writing to nil register");
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_ncpu32k_regfile_mp.sv
// Directed bench for ncpu32k_regfile_mp: default, no-bypass, no-zero-reg and wide configurations.
module tb_ncpu32k_regfile_mp;
    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 4;
    localparam int unsigned NW  = 2;
    localparam int unsigned BAW = 6;
    localparam int unsigned BDW = 64;
    localparam int unsigned BNR = 6;
    localparam int unsigned BNW = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ncpu32k_regfile_mp_if #(.AW(AW), .DW(DW), .NR(NR), .NW(NW)) ifa ();
    ncpu32k_regfile_mp_if #(.AW(AW), .DW(DW), .NR(NR), .NW(NW)) ifn ();
    ncpu32k_regfile_mp_if #(.AW(AW), .DW(DW), .NR(NR), .NW(NW)) ifz ();
    ncpu32k_regfile_mp_if #(.AW(BAW), .DW(BDW), .NR(BNR), .NW(BNW)) ifb ();

    assign ifn.raddr = ifa.raddr;
    assign ifn.re    = ifa.re;
    assign ifn.waddr = ifa.waddr;
    assign ifn.wdat  = ifa.wdat;
    assign ifn.we    = ifa.we;
    assign ifz.raddr = ifa.raddr;
    assign ifz.re    = ifa.re;
    assign ifz.waddr = ifa.waddr;
    assign ifz.wdat  = ifa.wdat;
    assign ifz.we    = ifa.we;

    ncpu32k_regfile_mp #(.AW(AW), .DW(DW), .NR(NR), .NW(NW), .ENABLE_BYPASS(1), .ZERO_REG(1))
        u_def (.clk(clk), .rst_n(rst_n), .rf(ifa.slave));
    ncpu32k_regfile_mp #(.AW(AW), .DW(DW), .NR(NR), .NW(NW), .ENABLE_BYPASS(0), .ZERO_REG(1))
        u_nobyp (.clk(clk), .rst_n(rst_n), .rf(ifn.slave));
    ncpu32k_regfile_mp #(.AW(AW), .DW(DW), .NR(NR), .NW(NW), .ENABLE_BYPASS(1), .ZERO_REG(0))
        u_nozero (.clk(clk), .rst_n(rst_n), .rf(ifz.slave));
    ncpu32k_regfile_mp #(.AW(BAW), .DW(BDW), .NR(BNR), .NW(BNW), .ENABLE_BYPASS(1), .ZERO_REG(1))
        u_big (.clk(clk), .rst_n(rst_n), .rf(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.re = '0;
        ifa.we = '0;
        ifb.re = '0;
        ifb.we = '0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] addr);
        ifa.re[k] = 1'b1;
        ifa.raddr[k*AW +: AW] = addr;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ifa.we[j] = 1'b1;
        ifa.waddr[j*AW +: AW] = addr;
        ifa.wdat[j*DW +: DW] = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        ifa.raddr = '0; ifa.waddr = '0; ifa.wdat = '0;
        ifb.raddr = '0; ifb.waddr = '0; ifb.wdat = '0;
        repeat (2) tick();
        for (int k = 0; k < int'(NR); k++) begin
            checks++;
            if (ifa.dout[k*DW +: DW] !== '0) begin
                errors++;
                $display("FAIL reset_init lane%0d got %h exp 0", k, ifa.dout[k*DW +: DW]);
            end
        end
        rst_n = 1'b1;
        set_wr(0, 5'd5, 32'h55);
        for (int k = 0; k < int'(NR); k++) set_rd(k, 5'd5);
        ifb.we[0] = 1'b1; ifb.waddr[0 +: BAW] = 6'd5; ifb.wdat[0 +: BDW] = 64'h55;
        for (int k = 0; k < int'(BNR); k++) begin
            ifb.re[k] = 1'b1; ifb.raddr[k*BAW +: BAW] = 6'd5;
        end
        tick();
        checks++;
        if (ifa.dout[0 +: DW] !== 32'h55) begin
            errors++;
            $display("FAIL reset_prefill got %h exp 00000055", ifa.dout[0 +: DW]);
        end
        // A write in flight when reset drops mid-cycle must be discarded.
        set_wr(0, 5'd6, 32'h66);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < int'(NR); k++) begin
            checks++;
            if (ifa.dout[k*DW +: DW] !== '0) begin
                errors++;
                $display("FAIL reset_async lane%0d got %h exp 0", k, ifa.dout[k*DW +: DW]);
            end
        end
        checks++;
        if (ifb.dout !== '0) begin
            errors++;
            $display("FAIL reset_async_big got %h exp 0", ifb.dout);
        end
        tick();
        idle();
        rst_n = 1'b1;
        for (int k = 0; k < int'(NR); k++) set_rd(k, (k == 0) ? 5'd6 : 5'd5);
        tick();
        for (int k = 0; k < int'(NR); k++) begin
            checks++;
            if (ifa.dout[k*DW +: DW] !== '0) begin
                errors++;
                $display("FAIL reset_cleared lane%0d got %h exp 0", k, ifa.dout[k*DW +: DW]);
            end
        end
        idle();
    endtask

    task automatic test_basic_rw();
        set_wr(0, 5'd3, 32'hDEADBEEF);
        tick();
        idle();
        set_rd(2, 5'd3);
        tick();
        checks++;
        if (ifa.dout[2*DW +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_read got %h exp deadbeef", ifa.dout[2*DW +: DW]);
        end
        idle();
        ifa.raddr[2*AW +: AW] = 5'd4;
        tick();
        checks++;
        if (ifa.dout[2*DW +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_hold got %h exp deadbeef", ifa.dout[2*DW +: DW]);
        end
    endtask

    task automatic test_bypass();
        set_wr(0, 5'd7, 32'h11);
        tick();
        idle();
        set_wr(1, 5'd7, 32'h22);
        set_rd(0, 5'd7);
        tick();
        checks++;
        if (ifa.dout[0 +: DW] !== 32'h22) begin
            errors++;
            $display("FAIL bypass_on got %h exp 00000022", ifa.dout[0 +: DW]);
        end
        checks++;
        if (ifn.dout[0 +: DW] !== 32'h11) begin
            errors++;
            $display("FAIL bypass_off got %h exp 00000011", ifn.dout[0 +: DW]);
        end
        idle();
        set_rd(0, 5'd7);
        tick();
        checks++;
        if (ifa.dout[0 +: DW] !== 32'h22) begin
            errors++;
            $display("FAIL bypass_on_next got %h exp 00000022", ifa.dout[0 +: DW]);
        end
        checks++;
        if (ifn.dout[0 +: DW] !== 32'h22) begin
            errors++;
            $display("FAIL bypass_off_next got %h exp 00000022", ifn.dout[0 +: DW]);
        end
        idle();
    endtask

    task automatic test_conflict();
        set_wr(0, 5'd9, 32'hAAAA);
        set_wr(1, 5'd9, 32'h5555);
        set_rd(3, 5'd9);
        tick();
        checks++;
        if (ifa.dout[3*DW +: DW] !== 32'h5555) begin
            errors++;
            $display("FAIL conflict_bypass got %h exp 00005555", ifa.dout[3*DW +: DW]);
        end
        checks++;
        if (ifn.dout[3*DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL conflict_old got %h exp 0", ifn.dout[3*DW +: DW]);
        end
        idle();
        set_rd(3, 5'd9);
        tick();
        checks++;
        if (ifa.dout[3*DW +: DW] !== 32'h5555) begin
            errors++;
            $display("FAIL conflict_stored got %h exp 00005555", ifa.dout[3*DW +: DW]);
        end
        checks++;
        if (ifn.dout[3*DW +: DW] !== 32'h5555) begin
            errors++;
            $display("FAIL conflict_stored_nb got %h exp 00005555", ifn.dout[3*DW +: DW]);
        end
        idle();
    endtask

    task automatic test_dual_write();
        set_wr(0, 5'd12, 32'hC);
        set_wr(1, 5'd13, 32'hD);
        tick();
        idle();
        set_rd(0, 5'd12);
        set_rd(1, 5'd13);
        tick();
        checks++;
        if (ifa.dout[0 +: DW] !== 32'hC) begin
            errors++;
            $display("FAIL dual_port0 got %h exp 0000000c", ifa.dout[0 +: DW]);
        end
        checks++;
        if (ifa.dout[DW +: DW] !== 32'hD) begin
            errors++;
            $display("FAIL dual_port1 got %h exp 0000000d", ifa.dout[DW +: DW]);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        set_rd(1, 5'd0);
        tick();
        checks++;
        if (ifa.dout[DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL zero_same got %h exp 0", ifa.dout[DW +: DW]);
        end
        checks++;
        if (ifz.dout[DW +: DW] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL nozero_same got %h exp ffffffff", ifz.dout[DW +: DW]);
        end
        idle();
        set_rd(1, 5'd0);
        tick();
        checks++;
        if (ifa.dout[DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL zero_next got %h exp 0", ifa.dout[DW +: DW]);
        end
        checks++;
        if (ifn.dout[DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL zero_next_nb got %h exp 0", ifn.dout[DW +: DW]);
        end
        checks++;
        if (ifz.dout[DW +: DW] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL nozero_next got %h exp ffffffff", ifz.dout[DW +: DW]);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        set_wr(0, 5'd20, 32'h1);
        tick();
        idle();
        set_wr(0, 5'd20, 32'h2);
        set_rd(0, 5'd20);
        tick();
        checks++;
        if (ifa.dout[0 +: DW] !== 32'h2) begin
            errors++;
            $display("FAIL b2b_bypass got %h exp 00000002", ifa.dout[0 +: DW]);
        end
        checks++;
        if (ifn.dout[0 +: DW] !== 32'h1) begin
            errors++;
            $display("FAIL b2b_old got %h exp 00000001", ifn.dout[0 +: DW]);
        end
        idle();
        set_wr(1, 5'd21, 32'h3);
        set_rd(0, 5'd20);
        set_rd(1, 5'd21);
        tick();
        checks++;
        if (ifa.dout[0 +: 2*DW] !== {32'h3, 32'h2}) begin
            errors++;
            $display("FAIL b2b_pair got %h exp 0000000300000002", ifa.dout[0 +: 2*DW]);
        end
        checks++;
        if (ifn.dout[0 +: 2*DW] !== {32'h0, 32'h2}) begin
            errors++;
            $display("FAIL b2b_pair_nb got %h exp 0000000000000002", ifn.dout[0 +: 2*DW]);
        end
        idle();
    endtask

    task automatic test_param();
        ifb.we = 3'b110;
        ifb.waddr[BAW +: BAW]   = 6'd63;
        ifb.wdat[BDW +: BDW]    = 64'hFFFF_FFFF_FFFF_FFFF;
        ifb.waddr[2*BAW +: BAW] = 6'd63;
        ifb.wdat[2*BDW +: BDW]  = 64'h0123456789ABCDEF;
        tick();
        idle();
        for (int k = 0; k < int'(BNR); k++) begin
            ifb.re[k] = 1'b1;
            ifb.raddr[k*BAW +: BAW] = 6'd63;
        end
        tick();
        for (int k = 0; k < int'(BNR); k++) begin
            checks++;
            if (ifb.dout[k*BDW +: BDW] !== 64'h0123456789ABCDEF) begin
                errors++;
                $display("FAIL param_lane%0d got %h exp 0123456789abcdef", k, ifb.dout[k*BDW +: BDW]);
            end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_rw();
        test_bypass();
        test_conflict();
        test_dual_write();
        test_zero_reg();
        test_back_to_back();
        test_param();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
